apb_master: RTL

APB requester that converts a simple valid/ready command interface into APB transfers (IDLE → SETUP → ACCESS) on the peripheral bus. It sits between an internal controller and the 8-bit-address / 16-bit-data APB peripherals. It supports back-to-back transfers, extends ACCESS for slave wait states, and aborts a transfer after a programmable number of wait cycles.

---
 rtl/apb_master.sv | 106 ++++++++++
 1 files changed

// File: rtl/apb_master.sv
// APB requester: valid/ready command in, APB IDLE/SETUP/ACCESS out, one-cycle response pulse.
// Slave wait states stretch ACCESS; a configurable wait budget aborts stuck transfers.
module apb_master #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 16
) (
    input  logic              pclk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              psel,
    output logic              penable,
    output logic [ADDR_W-1:0] paddr,
    output logic              pwrite,
    output logic [DATA_W-1:0] pwdata,
    input  logic              pready,
    input  logic [DATA_W-1:0] prdata
);
    typedef enum logic [2:0] {
        IDLE   = 3'b001,
        SETUP  = 3'b010,
        ACCESS = 3'b100
    } state_t;

    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_t              state_q;
    logic [CNT_W-1:0]    wait_cnt_q;
    logic [ADDR_W-1:0]   paddr_q;
    logic                pwrite_q;
    logic [DATA_W-1:0]   pwdata_q;
    logic                rsp_valid_q;
    logic [DATA_W-1:0]   rsp_rdata_q;
    logic                rsp_err_q;
    logic                accept;
    logic                timeout_hit;

    assign cmd_ready   = (state_q == IDLE) | ((state_q == ACCESS) & pready);
    assign accept      = cmd_valid & cmd_ready;
    // Fires on the TIMEOUT-th consecutive low-pready ACCESS cycle.
    assign timeout_hit = (TIMEOUT != 0) && (state_q == ACCESS) && !pready
                         && (wait_cnt_q == CNT_LAST);

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            wait_cnt_q  <= '0;
            paddr_q     <= '0;
            pwrite_q    <= 1'b0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            rsp_valid_q <= 1'b0;
            if (accept) begin
                paddr_q  <= cmd_addr;
                pwrite_q <= cmd_write;
                pwdata_q <= cmd_wdata;
            end
            case (state_q)
                IDLE: begin
                    if (accept) state_q <= SETUP;
                end
                SETUP: begin
                    state_q    <= ACCESS;
                    wait_cnt_q <= '0;
                end
                ACCESS: begin
                    if (pready) begin
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b0;
                        rsp_rdata_q <= pwrite_q ? '0 : prdata;
                        state_q     <= accept ? SETUP : IDLE;
                    end else if (timeout_hit) begin
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b1;
                        rsp_rdata_q <= '0;
                        state_q     <= IDLE;
                    end else if (wait_cnt_q != CNT_MAX) begin
                        wait_cnt_q <= wait_cnt_q + CNT_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign psel      = (state_q == SETUP) | (state_q == ACCESS);
    assign penable   = (state_q == ACCESS);
    assign paddr     = paddr_q;
    assign pwrite    = pwrite_q;
    assign pwdata    = pwdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
endmodule
